audio_ctrl_pio: RTL and testbench

Parametrised Avalon-MM control/status port for the audio subsystem; it is the next generation of the single-bit audio INIT output. It provides a DATA_W-bit output register with atomic set/clear, a self-timed pulse generator for codec init/reset strobes, and a synchronised status input. It sits on the Nios II system bus between the CPU and the audio codec interface logic.

---
 rtl/audio_ctrl_pio_pkg.sv | 22 ++
 rtl/audio_ctrl_pio_if.sv | 29 ++
 rtl/audio_ctrl_pio_sync_edge.sv | 42 ++++
 rtl/audio_ctrl_pio.sv | 193 +++++++++++++++++++
 tb/tb_audio_ctrl_pio.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_ctrl_pio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pio_pkg
// Shared definitions for the audio control/status PIO:
//   - register word addresses on the Avalon-MM slave port
//   - pulse generator FSM state encoding
// ---------------------------------------------------------------------------
package audio_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_SET     = 3'd1;
    localparam logic [2:0] ADDR_CLR     = 3'd2;
    localparam logic [2:0] ADDR_PULSE   = 3'd3;
    localparam logic [2:0] ADDR_IN      = 3'd4;
    localparam logic [2:0] ADDR_EDGE    = 3'd5;
    localparam logic [2:0] ADDR_IRQMASK = 3'd6;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/audio_ctrl_pio_if.sv
// ---------------------------------------------------------------------------
// audio_ctrl_pio_if
// Avalon-MM slave bus bundle for the audio control/status PIO.
//   address    : register word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from address
// Modports: master (CPU side), slave (PIO side).
// ---------------------------------------------------------------------------
interface audio_ctrl_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/audio_ctrl_pio_sync_edge.sv
// ---------------------------------------------------------------------------
// pio_sync_edge
// W-wide two-flop synchroniser for asynchronous status inputs, plus one
// delayed copy of the synchronised value to detect rising edges.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_async      : asynchronous inputs
//   o_sync       : synchronised value (two clocks of latency)
//   o_rise       : one-cycle strobe per bit on a 0->1 of o_sync
// ---------------------------------------------------------------------------
module pio_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_dly;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_dly;

endmodule

// File: rtl/audio_ctrl_pio.sv
// ---------------------------------------------------------------------------
// audio_ctrl_pio
// Avalon-MM control/status port for the audio codec interface.
//   - DATA register with atomic SET / CLR aliases
//   - self-timed pulse generator (PULSE_LEN cycles, retriggerable)
//   - synchronised status input, optional edge capture + interrupt
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (audio_ctrl_pio_if.slave), zero wait,
//                  read latency 0
//   out_port     : data_reg | pulse_mask
//   in_port      : asynchronous status inputs
//   irq          : |(edge & irqmask), tied 0 unless built with the macro
// Build option:
//   AUDIO_PIO_IRQ_EN : builds EDGE (addr 5, W1C), IRQMASK (addr 6) and irq.
// ---------------------------------------------------------------------------
module audio_ctrl_pio
    import audio_pio_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                IN_W      = 4,
    parameter int                PULSE_LEN = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    audio_ctrl_pio_if.slave      bus,
    output logic [DATA_W-1:0]    out_port,
    input  logic [IN_W-1:0]      in_port,
    output logic                 irq
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic              w_wr;
    logic [DATA_W-1:0] w_wd_data;
    logic [IN_W-1:0]   w_wd_in;
    logic              w_pulse_wr;
    logic              w_unused;

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mask;
    logic [CNT_W-1:0]  r_cnt;
    pulse_state_e      r_state;

    pulse_state_e      w_state_nxt;
    logic [DATA_W-1:0] w_mask_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [IN_W-1:0]   w_sync;
    logic [IN_W-1:0]   w_rise;

    assign w_wr       = bus.chipselect && !bus.write_n;
    assign w_wd_data  = bus.writedata[DATA_W-1:0];
    assign w_wd_in    = bus.writedata[IN_W-1:0];
    assign w_pulse_wr = w_wr && (bus.address == ADDR_PULSE);
    // Upper write-data bits are ignored by design.
    assign w_unused   = ^bus.writedata;

    // ------------------------------------------------------------------
    // DATA register with SET / CLR aliases
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VAL;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA: r_data <= w_wd_data;
                ADDR_SET:  r_data <= r_data | w_wd_data;
                ADDR_CLR:  r_data <= r_data & ~w_wd_data;
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pulse generator: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= PULSE_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A write in ACTIVE retriggers even when it adds no new bits; a write
    // of zero in IDLE has nothing to time and is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PULSE_IDLE:
                if (w_pulse_wr && (w_wd_data != '0)) w_state_nxt = PULSE_ACTIVE;
            PULSE_ACTIVE:
                if (!w_pulse_wr && (r_cnt == CNT_W'(1))) w_state_nxt = PULSE_IDLE;
            default:
                w_state_nxt = PULSE_IDLE;
        endcase
    end

    // NOTE: every signal driven in this always_comb is given a default
    // first, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_mask_nxt = r_mask;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            PULSE_IDLE: begin
                if (w_pulse_wr && (w_wd_data != '0)) begin
                    w_mask_nxt = r_mask | w_wd_data;
                    w_cnt_nxt  = CNT_W'(PULSE_LEN);
                end
            end
            PULSE_ACTIVE: begin
                // Retrigger takes priority over a concurrent expiry.
                if (w_pulse_wr) begin
                    w_mask_nxt = r_mask | w_wd_data;
                    w_cnt_nxt  = CNT_W'(PULSE_LEN);
                end else if (r_cnt == CNT_W'(1)) begin
                    w_mask_nxt = '0;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_mask_nxt = '0;
                w_cnt_nxt  = '0;
            end
        endcase
    end

    assign out_port = r_data | r_mask;

    // ------------------------------------------------------------------
    // Status input synchroniser
    // ------------------------------------------------------------------
    pio_sync_edge #(
        .W (IN_W)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

`ifdef AUDIO_PIO_IRQ_EN
    logic [IN_W-1:0] r_edge;
    logic [IN_W-1:0] r_irqmask;
    logic [IN_W-1:0] w_w1c;

    assign w_w1c = (w_wr && (bus.address == ADDR_EDGE)) ? w_wd_in : '0;

    // A new edge on the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge    <= '0;
            r_irqmask <= '0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_rise;
            if (w_wr && (bus.address == ADDR_IRQMASK)) r_irqmask <= w_wd_in;
        end
    end

    assign irq = |(r_edge & r_irqmask);
`else
    logic w_unused_rise;
    assign w_unused_rise = ^w_rise;
    assign irq           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux (zero-extended, zero wait states)
    // ------------------------------------------------------------------
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = 32'(r_data);
            ADDR_PULSE:   bus.readdata = 32'(r_mask);
            ADDR_IN:      bus.readdata = 32'(w_sync);
`ifdef AUDIO_PIO_IRQ_EN
            ADDR_EDGE:    bus.readdata = 32'(r_edge);
            ADDR_IRQMASK: bus.readdata = 32'(r_irqmask);
`endif
            default:      bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_audio_ctrl_pio.sv
// ---------------------------------------------------------------------------
// tb_audio_ctrl_pio
// Self-checking bench for audio_ctrl_pio (DATA_W=8, IN_W=4, PULSE_LEN=16,
// RESET_VAL=8'hA5). A register-level model tracks the programmer-visible
// state; a compare process checks out_port, irq and readdata on every
// falling edge. Directed scenarios pin the model with literal values, then
// a randomized phase exercises all addresses and in_port activity.
// Honors AUDIO_PIO_IRQ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_audio_ctrl_pio;

    localparam int         DATA_W    = 8;
    localparam int         IN_W      = 4;
    localparam int         PULSE_LEN = 16;
    localparam logic [7:0] RESET_VAL = 8'hA5;

    logic            clk;
    logic            reset_n;
    logic [7:0]      out_port;
    logic [3:0]      in_port;
    logic            irq;

    audio_ctrl_pio_if bus_if ();

    audio_ctrl_pio #(
        .DATA_W    (DATA_W),
        .IN_W      (IN_W),
        .PULSE_LEN (PULSE_LEN),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .out_port (out_port),
        .in_port  (in_port),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: register contents, remaining pulse cycles, and
    // the history of in_port as sampled at each clock edge.
    // ------------------------------------------------------------------
    logic [7:0] m_data;
    logic [7:0] m_pmask;
    int         m_prem;
    logic [3:0] m_hist [3];
    logic [3:0] m_edge;
    logic [3:0] m_imask;
    logic [3:0] m_rise;
    logic       m_wr;
    logic [7:0] m_wd8;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  = RESET_VAL;
            m_pmask = '0;
            m_prem  = 0;
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_edge  = '0;
            m_imask = '0;
        end else begin
            m_wr  = bus_if.chipselect && !bus_if.write_n;
            m_wd8 = bus_if.writedata[7:0];
            // A rising edge seen by the edge register now is the value
            // sampled two edges ago against the one three edges ago.
            m_rise = m_hist[1] & ~m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = in_port;
            if (m_wr && bus_if.address == 3'd0) m_data = m_wd8;
            if (m_wr && bus_if.address == 3'd1) m_data = m_data | m_wd8;
            if (m_wr && bus_if.address == 3'd2) m_data = m_data & ~m_wd8;
            if (m_wr && bus_if.address == 3'd3 && (m_wd8 != 0 || m_prem > 0)) begin
                m_pmask = m_pmask | m_wd8;
                m_prem  = PULSE_LEN;
            end else if (m_prem > 0) begin
                m_prem = m_prem - 1;
                if (m_prem == 0) m_pmask = '0;
            end
            if (m_wr && bus_if.address == 3'd5)
                m_edge = m_edge & ~bus_if.writedata[3:0];
            m_edge = m_edge | m_rise;
            if (m_wr && bus_if.address == 3'd6) m_imask = bus_if.writedata[3:0];
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd3: return {24'd0, m_pmask};
            3'd4: return {28'd0, m_hist[1]};
`ifdef AUDIO_PIO_IRQ_EN
            3'd5: return {28'd0, m_edge};
            3'd6: return {28'd0, m_imask};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_irq();
`ifdef AUDIO_PIO_IRQ_EN
        return |(m_edge & m_imask);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("out_port", {24'd0, out_port}, {24'd0, m_data | m_pmask});
            check("irq", {31'd0, irq}, {31'd0, exp_irq()});
            check("readdata", bus_if.readdata, exp_rd(bus_if.address));
        end
    end

    // ------------------------------------------------------------------
    // Bus driver: one call = one clock of bus activity.
    // ------------------------------------------------------------------
    task automatic drive(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = a;
        bus_if.writedata  = d;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b1, 1'b1, a, $urandom);
    endtask

    int cnt0;
    int cnt1;

    initial begin
        reset_n             = 1'b0;
        in_port             = '0;
        bus_if.chipselect   = 1'b0;
        bus_if.write_n      = 1'b1;
        bus_if.address      = 3'd3;
        bus_if.writedata    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_out_port", {24'd0, out_port}, 32'h0000_00A5);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rd_pulse", bus_if.readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // DATA / SET / CLR
        wr(3'd0, 32'h0000_000F);
        wr(3'd1, 32'hFFFF_FFF0);
        wr(3'd2, 32'h0000_0081);
        rd(3'd0);
        #3;
        check("set_clr_out_port", {24'd0, out_port}, 32'h0000_007E);
        check("set_clr_rd_data", bus_if.readdata, 32'h0000_007E);

        // Single pulse, 16 cycles
        wr(3'd0, 32'd0);
        wr(3'd3, 32'h0000_0001);
        cnt0 = 0;
        for (int i = 0; i < 40; i++) begin
            rd(3'd4);
            #3;
            if (out_port[0]) cnt0++;
        end
        check("pulse_len", cnt0, 16);
        check("pulse_end_out", {24'd0, out_port}, 32'd0);

        // Retrigger at cycle 10 with bit 1
        wr(3'd3, 32'h0000_0001);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 9) wr(3'd3, 32'h0000_0002);
            else        rd(3'd3);
            #3;
            if (out_port[0]) cnt0++;
            if (out_port[1]) cnt1++;
            if (i == 25) check("retrig_last_high", {24'd0, out_port}, 32'h0000_0003);
            if (i == 26) check("retrig_first_low", {24'd0, out_port}, 32'd0);
        end
        check("retrig_bit0_len", cnt0, 26);
        check("retrig_bit1_len", cnt1, 16);

        // Reset mid-pulse
        wr(3'd3, 32'h0000_0010);
        repeat (5) rd(3'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_pulse", {24'd0, out_port}, 32'h0000_00A5);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(3'd3);
        #3;
        check("pulse_mask_after_reset", bus_if.readdata, 32'd0);
        check("out_after_reset", {24'd0, out_port}, 32'h0000_00A5);

`ifdef AUDIO_PIO_IRQ_EN
        // Edge capture and interrupt
        wr(3'd6, 32'h0000_0002);
        in_port = 4'h2;
        rd(3'd4);
        rd(3'd4);
        #3;
        check("in_sync", bus_if.readdata, 32'h0000_0002);
        check("irq_before_edge", {31'd0, irq}, 32'd0);
        rd(3'd5);
        #3;
        check("edge_set", bus_if.readdata, 32'h0000_0002);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(3'd5, 32'h0000_0002);
        rd(3'd5);
        #3;
        check("irq_w1c", {31'd0, irq}, 32'd0);
        check("edge_w1c", bus_if.readdata, 32'd0);
        in_port = 4'h0;
        repeat (3) rd(3'd4);
        in_port = 4'h2;
        rd(3'd4);
        wr(3'd5, 32'h0000_0002);
        rd(3'd5);
        #3;
        check("w1c_vs_new_edge", bus_if.readdata, 32'h0000_0002);
        check("irq_w1c_vs_edge", {31'd0, irq}, 32'd1);
        wr(3'd5, 32'h0000_000F);
`else
        // Edge/IRQMASK not built
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        in_port = 4'hF;
        repeat (4) rd(3'd4);
        rd(3'd5);
        #3;
        check("edge_absent", bus_if.readdata, 32'd0);
        rd(3'd6);
        #3;
        check("irqmask_absent", bus_if.readdata, 32'd0);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        in_port = 4'h0;
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] d;
            cs = ($urandom_range(0, 99) < 70);
            wn = !(cs && ($urandom_range(0, 3) == 0));
            a  = 3'($urandom_range(0, 7));
            if (a == 3'd3 && !wn && $urandom_range(0, 3) != 0) wn = 1'b1;
            d  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            drive(cs, wn, a, d);
            if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
        end
        drive(1'b0, 1'b1, 3'd0, 32'd0);
        @(posedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
